// File: rtl/peri_bcd.sv
// peri_bcd: holds one 32-bit binary value and presents it as 8-digit packed BCD,
// saturating to all nines when the value needs more than 8 decimal digits.
module peri_bcd (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_bcd_i,
    input  logic [31:0] data_i,
    output logic [31:0] salida_o
);

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned DIGITS   = 10;
    localparam int unsigned BCD_W    = 4 * DIGITS;
    localparam int unsigned SCRATCH_W = BCD_W + DATA_W;
    localparam int unsigned OUT_W    = 32;

    logic [DATA_W-1:0]    value_q;
    logic [SCRATCH_W-1:0] scratch;
    logic [BCD_W-1:0]     bcd;
    logic                 overflow;

    // Value register: cleared asynchronously, loaded on write enable.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            value_q <= '0;
        end else if (we_bcd_i) begin
            value_q <= data_i;
        end
    end

    // Double dabble: add 3 to any digit >= 5, then shift, once per input bit.
    always_comb begin
        scratch = {BCD_W'(0), value_q};
        for (int i = 0; i < int'(DATA_W); i++) begin
            for (int d = 0; d < int'(DIGITS); d++) begin
                if (scratch[int'(DATA_W) + 4*d +: 4] >= 4'd5) begin
                    scratch[int'(DATA_W) + 4*d +: 4] = scratch[int'(DATA_W) + 4*d +: 4] + 4'd3;
                end
            end
            scratch = scratch << 1;
        end
        bcd = scratch[SCRATCH_W-1:DATA_W];
    end

    // Any nonzero digit above digit 7 means the value exceeds 99,999,999.
    always_comb begin
        overflow = |bcd[BCD_W-1:OUT_W];
        salida_o = overflow ? 32'h9999_9999 : bcd[OUT_W-1:0];
    end

endmodule

// File: tb/tb_peri_bcd.sv
// Testbench for peri_bcd: directed cases plus random writes against a decimal model.
module tb_peri_bcd;

    logic        clk_i;
    logic        rst_i;
    logic        we_bcd_i;
    logic [31:0] data_i;
    logic [31:0] salida_o;

    int unsigned checks;
    int unsigned passes;
    logic [31:0] model_reg;

    peri_bcd dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .we_bcd_i (we_bcd_i),
        .data_i   (data_i),
        .salida_o (salida_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference: decimal digits by repeated division, saturated above 8 digits.
    function automatic logic [31:0] ref_bcd(input logic [31:0] v);
        logic [31:0] r;
        longint unsigned n;
        r = '0;
        n = longint'(v);
        if (n > 64'd99999999) begin
            r = 32'h9999_9999;
        end else begin
            for (int k = 0; k < 8; k++) begin
                r[4*k +: 4] = 4'(n % 10);
                n = n / 10;
            end
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] exp);
        checks++;
        assert (salida_o === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, salida_o, exp);
    endtask

    // Drive a write on one edge, deassert, then sample just after the edge.
    task automatic write(input logic [31:0] v);
        @(negedge clk_i);
        we_bcd_i = 1'b1;
        data_i   = v;
        @(posedge clk_i);
        #1;
        we_bcd_i = 1'b0;
        if (rst_i) model_reg = v;
    endtask

    task automatic idle_cycle();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [31:0] v;
        checks    = 0;
        passes    = 0;
        model_reg = '0;
        rst_i     = 1'b0;
        we_bcd_i  = 1'b0;
        data_i    = 32'h1234_5678;

        // Reset state and release with no write
        #2;
        check("in_reset", 32'h0000_0000);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        idle_cycle();
        check("after_release", 32'h0000_0000);
        idle_cycle();
        check("release_hold", 32'h0000_0000);

        // Single write then hold for three cycles
        write(32'd345231);
        check("w345231", 32'h0034_5231);
        for (int c = 0; c < 3; c++) begin
            idle_cycle();
            check("w345231_hold", 32'h0034_5231);
        end

        // Write, then data_i changes while disabled
        write(32'd134214);
        check("w134214", 32'h0013_4214);
        @(negedge clk_i);
        data_i = 32'd777;
        idle_cycle();
        data_i = 32'hFFFF_FFFF;
        idle_cycle();
        check("w134214_data_ignored", 32'h0013_4214);

        write(32'd999999);
        check("w999999", 32'h0099_9999);

        // Boundaries
        write(32'd0);
        check("b_zero", 32'h0000_0000);
        write(32'd99999999);
        check("b_max8", 32'h9999_9999);
        write(32'd100000000);
        check("b_sat", 32'h9999_9999);
        write(32'hFFFF_FFFF);
        check("b_allones", 32'h9999_9999);

        // Back-to-back writes
        @(negedge clk_i);
        we_bcd_i = 1'b1;
        data_i   = 32'd11;
        @(posedge clk_i);
        #1;
        check("b2b_first", 32'h0000_0011);
        @(negedge clk_i);
        data_i = 32'd4096;
        @(posedge clk_i);
        #1;
        we_bcd_i = 1'b0;
        check("b2b_second", 32'h0000_4096);

        // Reset coinciding with a write edge discards the write
        @(negedge clk_i);
        we_bcd_i = 1'b1;
        data_i   = 32'd5555;
        rst_i    = 1'b0;
        @(posedge clk_i);
        #1;
        check("rst_vs_write", 32'h0000_0000);
        we_bcd_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        idle_cycle();
        idle_cycle();
        check("rst_release_hold", 32'h0000_0000);

        // Mid-cycle reset clears output before the next edge
        write(32'd12345678);
        check("w12345678", 32'h1234_5678);
        #2;
        rst_i = 1'b0;
        #1;
        check("midcycle_rst", 32'h0000_0000);
        @(negedge clk_i);
        rst_i = 1'b1;
        model_reg = '0;
        idle_cycle();
        check("midcycle_rst_hold", 32'h0000_0000);

        // Random writes and idle cycles against the model
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 1) == 0) v = $urandom_range(0, 99999999);
            else v = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                write(v);
            end else begin
                @(negedge clk_i);
                data_i = v;
                idle_cycle();
            end
            check("random", ref_bcd(model_reg));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/peri_bcd.md
PERI_BCD -- requirements
Module: peri_bcd

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset SHALL be asynchronous and active-low.
REQ-002 clk_i  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  asynchronous active-low reset; 0 = reset asserted.
REQ-004 we_bcd_i  input  1  write enable; when 1 at a rising clk_i edge, data_i is captured.
REQ-005 data_i  input  32  unsigned binary value to convert.
REQ-006 salida_o  output  32  packed BCD of the captured value: 8 digits, digit 0 (units) in bits [3:0], digit 7 in bits [31:28].

Function
REQ-007 The block SHALL contain one 32-bit value register, the only architectural state.
REQ-008 At a rising clk_i edge with rst_i=1 and we_bcd_i=1, the register SHALL load data_i.
REQ-009 At a rising clk_i edge with we_bcd_i=0, the register SHALL hold its value.
REQ-010 salida_o SHALL be a purely combinational function of the register, with no further pipeline stage.
REQ-011 Latency: salida_o SHALL reflect a new write immediately after the capturing edge plus combinational delay, with zero extra cycles.
REQ-012 Conversion SHALL be exact unsigned binary-to-decimal, using combinational shift-add-3 (double dabble) over all 32 input bits to produce 10 decimal digits internally.
REQ-013 If the register value is at most 99,999,999, salida_o SHALL equal the low 8 BCD digits, and each nibble SHALL be in 0..9.
REQ-014 If the register value exceeds 99,999,999, salida_o SHALL saturate to 32'h9999_9999.
REQ-015 Leading decimal zeros SHALL be output as 0 nibbles, with no blanking.
REQ-016 data_i SHALL be ignored while we_bcd_i=0, and changes to it SHALL NOT affect salida_o.
REQ-017 Back-to-back writes on consecutive edges SHALL each be captured; salida_o SHALL follow the most recent one.

Reset
REQ-018 While rst_i=0, the register SHALL clear to 0 immediately, independent of clk_i, and salida_o SHALL be 32'h0000_0000.
REQ-019 When rst_i=0 coincides with a rising edge where we_bcd_i=1, reset SHALL win and the write SHALL be discarded.
REQ-020 After rst_i returns to 1, the register SHALL hold 0 until the next write.
REQ-021 Reset asserted between writes SHALL discard the stored value, and salida_o SHALL go to 0 without waiting for a clock edge.

Verification
REQ-022 Reset then release, no write -> salida_o = 32'h0000_0000.
REQ-023 Write data_i=32'd345231 for one edge, then we_bcd_i=0 -> salida_o = 32'h0034_5231, checked directly after the edge and held for the following 3 cycles.
REQ-024 Write 32'd134214 after the previous value, then change data_i with we_bcd_i=0 -> salida_o = 32'h0013_4214, unchanged by data_i.
REQ-025 Write 32'd999999 -> salida_o = 32'h0099_9999, checked as soon as we_bcd_i deasserts after the capturing edge.
REQ-026 Boundary writes -> results as follows:
  - 32'd0 -> 32'h0000_0000
  - 32'd99999999 -> 32'h9999_9999
  - 32'd100000000 -> 32'h9999_9999 (saturated)
  - 32'hFFFF_FFFF -> 32'h9999_9999
REQ-027 Write 32'd12345678, then assert rst_i=0 mid-cycle -> salida_o = 32'h0000_0000 before the next clk_i edge.
